dbgnoc_conf_reader: RTL and testbench

Debug-NoC initiator that reads a run of 16-bit configuration registers from a debug module's configuration interface. It sends a read-request packet, collects the response packet, and streams the returned words out over a valid/ready port. It sits at the host/debug-controller end of the debug NoC, opposite the per-module configuration responders.

---
 rtl/dbgnoc_conf_reader_if.sv | 39 +++
 rtl/dbgnoc_conf_reader.sv | 166 ++++++++++++++++
 tb/tb_dbgnoc_conf_reader.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbgnoc_conf_reader_if.sv
// Request, read-data and debug-NoC flit signals of the configuration reader.
// The master modport is the reader itself; slave is the host/NoC side.
interface dbgnoc_conf_reader_if #(
  parameter int DBG_NOC_FLIT_DATA_WIDTH = 16,
  parameter int DBG_NOC_FLIT_TYPE_WIDTH = 2
);
  localparam int FW = DBG_NOC_FLIT_DATA_WIDTH + DBG_NOC_FLIT_TYPE_WIDTH;

  logic                               req_valid;
  logic                               req_ready;
  logic [4:0]                         req_dest;
  logic [15:0]                        req_addr;
  logic [3:0]                         req_count;
  logic [DBG_NOC_FLIT_DATA_WIDTH-1:0] rd_data;
  logic                               rd_valid;
  logic                               rd_ready;
  logic                               done;
  logic                               err;
  logic [FW-1:0]                      dbgnoc_out_flit;
  logic                               dbgnoc_out_valid;
  logic                               dbgnoc_out_ready;
  logic [FW-1:0]                      dbgnoc_in_flit;
  logic                               dbgnoc_in_valid;
  logic                               dbgnoc_in_ready;

  modport master (
    input  req_valid, req_dest, req_addr, req_count, rd_ready,
           dbgnoc_out_ready, dbgnoc_in_flit, dbgnoc_in_valid,
    output req_ready, rd_data, rd_valid, done, err,
           dbgnoc_out_flit, dbgnoc_out_valid, dbgnoc_in_ready
  );

  modport slave (
    output req_valid, req_dest, req_addr, req_count, rd_ready,
           dbgnoc_out_ready, dbgnoc_in_flit, dbgnoc_in_valid,
    input  req_ready, rd_data, rd_valid, done, err,
           dbgnoc_out_flit, dbgnoc_out_valid, dbgnoc_in_ready
  );
endinterface

// File: rtl/dbgnoc_conf_reader.sv
// Debug-NoC initiator: sends a config read request packet, streams the
// response words out over valid/ready and signals done/err per transaction.
module dbgnoc_conf_reader #(
  parameter int          DBG_NOC_FLIT_DATA_WIDTH = 16,
  parameter int          DBG_NOC_FLIT_TYPE_WIDTH = 2,
  parameter logic [4:0]  SRC_ADDR                = 5'd0,
  parameter int          MAX_WORDS               = 8,
  parameter int          TIMEOUT_CYCLES          = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  dbgnoc_conf_reader_if.master bus
);
  localparam int DW    = DBG_NOC_FLIT_DATA_WIDTH;
  localparam int FW    = DBG_NOC_FLIT_DATA_WIDTH + DBG_NOC_FLIT_TYPE_WIDTH;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] TYPE_BODY = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_LAST = 2'b10;

  typedef enum logic [2:0] {
    IDLE, SEND_HDR, SEND_ADDR, SEND_CNT, WAIT_HDR, RECV, DRAIN, FIN
  } state_t;

  state_t           state;
  logic [4:0]       dest;
  logic [15:0]      addr;
  logic [3:0]       count;
  logic [3:0]       words;
  logic [TMO_W-1:0] tmo;
  logic [FW-1:0]    out_flit;
  logic             out_valid;
  logic             done;
  logic             err;

  logic [1:0]       in_type;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic             in_hs;
  logic             out_hs;
  logic             hdr_ok;
  logic             last_word;
  logic             count_ok;
  logic             waiting;

  always_comb begin
    in_type   = bus.dbgnoc_in_flit[FW-1:DW];
    in_data   = bus.dbgnoc_in_flit[DW-1:0];
    in_ready  = 1'b0;
    case (state)
      IDLE, WAIT_HDR, DRAIN: in_ready = 1'b1;
      // A header arriving mid-response is swallowed, never forwarded
      RECV:                  in_ready = (in_type == TYPE_HEAD) ? 1'b1 : bus.rd_ready;
      default:               in_ready = 1'b0;
    endcase
    in_hs     = bus.dbgnoc_in_valid && in_ready;
    out_hs    = out_valid && bus.dbgnoc_out_ready;
    hdr_ok    = (in_type == TYPE_HEAD) && (in_data[10:8] == 3'b001) && (in_data[4:0] == dest);
    last_word = (words + 4'd1) == count;
    count_ok  = (bus.req_count != 4'd0) && (int'(bus.req_count) <= MAX_WORDS);
    waiting   = (state == WAIT_HDR) || (state == RECV) || (state == DRAIN);
  end

  assign bus.req_ready        = (state == IDLE) && !rst;
  assign bus.dbgnoc_in_ready  = in_ready;
  assign bus.rd_valid         = (state == RECV) && bus.dbgnoc_in_valid && (in_type != TYPE_HEAD);
  assign bus.rd_data          = (state == RECV) ? in_data : '0;
  assign bus.dbgnoc_out_flit  = out_flit;
  assign bus.dbgnoc_out_valid = out_valid;
  assign bus.done             = done;
  assign bus.err              = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dest      <= '0;
      addr      <= '0;
      count     <= '0;
      words     <= '0;
      tmo       <= '0;
      out_flit  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      tmo  <= '0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            dest  <= bus.req_dest;
            addr  <= bus.req_addr;
            count <= bus.req_count;
            words <= '0;
            if (count_ok) begin
              err       <= 1'b0;
              out_valid <= 1'b1;
              out_flit  <= {TYPE_HEAD, bus.req_dest, 6'b0, SRC_ADDR};
              state     <= SEND_HDR;
            end else begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        SEND_HDR: if (out_hs) begin
          out_flit <= {TYPE_BODY, addr};
          state    <= SEND_ADDR;
        end
        SEND_ADDR: if (out_hs) begin
          out_flit <= {TYPE_LAST, DW'(count)};
          state    <= SEND_CNT;
        end
        SEND_CNT: if (out_hs) begin
          out_valid <= 1'b0;
          state     <= WAIT_HDR;
        end
        WAIT_HDR: if (in_hs && in_type == TYPE_HEAD) begin
          if (hdr_ok) begin
            state <= RECV;
          end else begin
            err   <= 1'b1;
            state <= DRAIN;
          end
        end
        RECV: if (in_hs) begin
          if (in_type == TYPE_HEAD) begin
            err   <= 1'b1;
            state <= DRAIN;
          end else begin
            words <= words + 4'd1;
            if (in_type == TYPE_LAST) begin
              err   <= !last_word;
              done  <= 1'b1;
              state <= FIN;
            end else if (last_word) begin
              err   <= 1'b1;
              state <= DRAIN;
            end
          end
        end
        DRAIN: if (in_hs && in_type == TYPE_LAST) begin
          done  <= 1'b1;
          state <= FIN;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase

      // Timeout only fires on cycles without an accepted flit, so a final
      // handshake coinciding with expiry completes normally.
      if (waiting && !in_hs) begin
        if (tmo == TMO_LIMIT) begin
          err   <= 1'b1;
          done  <= 1'b1;
          state <= FIN;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dbgnoc_conf_reader.sv
// Self-checking bench: scripted responder/consumer around the reader, with a
// packet-level reference model deciding delivered words and the error flag.
module tb_dbgnoc_conf_reader;
  localparam int         TMO  = 16;
  localparam int         MAXW = 8;
  localparam logic [4:0] SRC  = 5'd0;
  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_LAST = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dbgnoc_conf_reader_if #(.DBG_NOC_FLIT_DATA_WIDTH(16), .DBG_NOC_FLIT_TYPE_WIDTH(2)) bus ();

  dbgnoc_conf_reader #(
    .DBG_NOC_FLIT_DATA_WIDTH(16),
    .DBG_NOC_FLIT_TYPE_WIDTH(2),
    .SRC_ADDR(SRC),
    .MAX_WORDS(MAXW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] rsp[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream-level outcome: words delivered to rd_* and final err flag.
  function automatic void model(input int cnt, input logic [4:0] dest, input logic [17:0] r[$],
                                output int nd, output bit e);
    nd = 0;
    e  = 1'b1;
    if (cnt < 1 || cnt > MAXW || r.size() == 0) return;
    if (r[0][17:16] != T_HEAD || r[0][10:8] != 3'b001 || r[0][4:0] != dest) return;
    for (int i = 1; i < r.size(); i++) begin
      if (r[i][17:16] == T_HEAD) return;
      nd++;
      if (r[i][17:16] == T_LAST) begin
        e = (nd != cnt);
        return;
      end
      if (nd == cnt) return;
    end
  endfunction

  // kind: 0 exact, 1 one word short, 2 too long, 3 bad header, 4 header inside data
  task automatic build_rsp(input int kind, input logic [4:0] dest, input int cnt);
    int n;
    int h;
    logic [1:0] t;
    rsp.delete();
    case (kind)
      1:       n = (cnt > 1) ? cnt - 1 : cnt;
      2:       n = cnt + 1 + int'($urandom_range(0, 2));
      4:       n = cnt + 1;
      default: n = cnt;
    endcase
    h = (kind == 4) ? int'($urandom_range(0, n - 2)) : -1;
    if (kind == 3)
      rsp.push_back({T_HEAD, SRC, 3'b001, 3'b000, dest ^ 5'd1});
    else
      rsp.push_back({T_HEAD, SRC, 3'b001, 3'b000, dest});
    for (int i = 0; i < n; i++) begin
      t = (i == n - 1) ? T_LAST : ((i == h) ? T_HEAD : T_BODY);
      rsp.push_back({t, 16'($urandom)});
    end
  endtask

  // or_mode: 0 ready, 1 random, 2 stall 3 cycles after first flit
  // rr_mode: 0 ready, 1 toggle, 2 mostly ready, 3 ready only on the timeout-expiry cycle
  task automatic run_txn(input string name, input logic [4:0] dest, input logic [15:0] addr,
                         input logic [3:0] cnt, input int or_mode, input int rr_mode,
                         input bit gaps, input int abort_at);
    logic [17:0] exp_out[$];
    logic [17:0] prev_out;
    bit   prev_stall, accepted, presenting, started, done_seen, tmo_case, aborted;
    bit   in_hs_s, e_err, hdr_seen, exp_rv;
    int   nd, n_out, words, ridx, last_out_iter, hs_iter, hdr_iter, hold;

    model(int'(cnt), dest, rsp, nd, e_err);
    if (cnt >= 1 && int'(cnt) <= MAXW) begin
      exp_out.push_back({T_HEAD, dest, 6'b0, SRC});
      exp_out.push_back({T_BODY, addr});
      exp_out.push_back({T_LAST, 12'h000, cnt});
    end
    tmo_case = (exp_out.size() != 0) && (rsp.size() == 0);
    prev_out = '0; prev_stall = 0; accepted = 0; presenting = 0; started = 0;
    done_seen = 0; aborted = 0; in_hs_s = 0; hdr_seen = 0;
    n_out = 0; words = 0; ridx = 0; last_out_iter = 0; hs_iter = 0; hdr_iter = 0; hold = 0;

    for (int it = 0; it < 400 && !done_seen && !aborted; it++) begin
      if (in_hs_s) begin
        if (ridx == 0) begin hdr_seen = 1; hdr_iter = it - 1; end
        void'(rsp.pop_front());
        ridx++;
        presenting = 0;
      end
      bus.req_valid = !accepted;
      bus.req_dest  = dest;
      bus.req_addr  = addr;
      bus.req_count = cnt;
      case (or_mode)
        0: bus.dbgnoc_out_ready = 1'b1;
        1: bus.dbgnoc_out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (n_out == 1 && hold < 3) begin bus.dbgnoc_out_ready = 1'b0; hold++; end
          else bus.dbgnoc_out_ready = 1'b1;
        end
      endcase
      case (rr_mode)
        0: bus.rd_ready = 1'b1;
        1: bus.rd_ready = (it % 2) == 0;
        2: bus.rd_ready = $urandom_range(0, 3) != 0;
        default: bus.rd_ready = hdr_seen && (it == hdr_iter + TMO);
      endcase
      if (started && rsp.size() > 0) begin
        if (!presenting && !(gaps && $urandom_range(0, 3) == 0)) presenting = 1;
        bus.dbgnoc_in_valid = presenting;
        if (presenting) bus.dbgnoc_in_flit = rsp[0];
      end else begin
        bus.dbgnoc_in_valid = 1'b0;
      end

      @(negedge clk);
      if (bus.req_valid && bus.req_ready) accepted = 1;
      if (prev_stall) begin
        check({name, "/out_hold_valid"}, 32'(bus.dbgnoc_out_valid), 1);
        check({name, "/out_hold_flit"}, 32'(bus.dbgnoc_out_flit), 32'(prev_out));
      end
      if (bus.dbgnoc_out_valid && bus.dbgnoc_out_ready) begin
        if (n_out < exp_out.size())
          check({name, "/out_flit"}, 32'(bus.dbgnoc_out_flit), 32'(exp_out[n_out]));
        else
          check({name, "/out_count"}, n_out + 1, exp_out.size());
        if (or_mode == 0 && n_out > 0) check({name, "/out_no_bubble"}, it, last_out_iter + 1);
        n_out++;
        last_out_iter = it;
        if (n_out == exp_out.size()) begin started = 1; hs_iter = it; end
      end
      prev_stall = bus.dbgnoc_out_valid && !bus.dbgnoc_out_ready;
      prev_out   = bus.dbgnoc_out_flit;

      exp_rv = bus.dbgnoc_in_valid && ridx >= 1 && ridx <= nd;
      check({name, "/rd_valid"}, 32'(bus.rd_valid), 32'(exp_rv));
      if (bus.rd_valid && bus.dbgnoc_in_valid) begin
        check({name, "/in_ready_mirror"}, 32'(bus.dbgnoc_in_ready), 32'(bus.rd_ready));
        if (bus.rd_ready) begin
          check({name, "/rd_data"}, 32'(bus.rd_data), 32'(rsp[0][15:0]));
          words++;
          if (abort_at > 0 && words == abort_at) aborted = 1;
        end
      end
      in_hs_s = bus.dbgnoc_in_valid && bus.dbgnoc_in_ready;

      if (bus.done) begin
        done_seen = 1;
        check({name, "/err"}, 32'(bus.err), 32'(e_err));
        check({name, "/words"}, words, nd);
        check({name, "/rsp_consumed"}, rsp.size(), 0);
        check({name, "/out_flits"}, n_out, exp_out.size());
        if (tmo_case) check({name, "/tmo_latency"}, it - hs_iter - 1, TMO);
      end
      @(posedge clk); #1;
    end
    if (aborted) return;
    check({name, "/done_seen"}, 32'(done_seen), 1);
    bus.req_valid = 1'b0;
    bus.dbgnoc_in_valid = 1'b0;
    @(negedge clk);
    check({name, "/done_pulse"}, 32'(bus.done), 0);
    check({name, "/back_idle"}, 32'(bus.req_ready), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] rc;
    bus.req_valid = 0; bus.req_dest = '0; bus.req_addr = '0; bus.req_count = '0;
    bus.rd_ready = 0; bus.dbgnoc_out_ready = 0; bus.dbgnoc_in_flit = '0; bus.dbgnoc_in_valid = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst/req_ready", 32'(bus.req_ready), 0);
    check("rst/out_valid", 32'(bus.dbgnoc_out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle/req_ready", 32'(bus.req_ready), 1);
    check("idle/in_ready", 32'(bus.dbgnoc_in_ready), 1);
    check("idle/done", 32'(bus.done), 0);
    check("idle/err", 32'(bus.err), 0);
    check("idle/rd_data", 32'(bus.rd_data), 0);
    @(posedge clk); #1;

    rsp = '{{T_HEAD, 16'h0103}, {T_LAST, 16'h0600}};
    run_txn("t1_basic", 5'd3, 16'h0000, 4'd1, 0, 0, 0, 0);

    build_rsp(0, 5'd7, 4);
    run_txn("t2_backpressure", 5'd7, 16'h1234, 4'd4, 2, 1, 0, 0);

    build_rsp(1, 5'd2, 3);
    run_txn("t3_short", 5'd2, 16'h0040, 4'd3, 0, 0, 0, 0);
    build_rsp(0, 5'd2, 3);
    run_txn("t3_after", 5'd2, 16'h0040, 4'd3, 0, 0, 0, 0);

    rsp = '{{T_HEAD, 16'h0109}, {T_BODY, 16'h1111}, {T_BODY, 16'h2222},
            {T_BODY, 16'h3333}, {T_LAST, 16'h4444}};
    run_txn("t4_long", 5'd9, 16'h0100, 4'd2, 0, 0, 0, 0);

    rsp.delete();
    run_txn("t5_timeout", 5'd3, 16'h0200, 4'd2, 0, 0, 0, 0);
    rsp = '{{T_HEAD, 16'h0104}, {T_BODY, 16'haaaa}, {T_LAST, 16'hbbbb}};
    run_txn("t5_bad_src", 5'd3, 16'h0300, 4'd2, 0, 0, 0, 0);
    rsp.delete();
    run_txn("t5_count0", 5'd3, 16'h0300, 4'd0, 0, 0, 0, 0);
    run_txn("t5_count9", 5'd3, 16'h0300, 4'd9, 0, 0, 0, 0);

    rsp = '{{T_HEAD, 16'h0105}, {T_LAST, 16'h5a5a}};
    run_txn("tie_hs_vs_tmo", 5'd5, 16'h0010, 4'd1, 0, 3, 0, 0);

    build_rsp(0, 5'd6, 4);
    run_txn("t6_abort", 5'd6, 16'h0500, 4'd4, 0, 0, 0, 1);
    rst = 1'b1;
    bus.dbgnoc_in_valid = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("t6/rst_req_ready", 32'(bus.req_ready), 0);
    check("t6/rst_done", 32'(bus.done), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6/rst_req_ready2", 32'(bus.req_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6/req_ready", 32'(bus.req_ready), 1);
      check("t6/out_valid", 32'(bus.dbgnoc_out_valid), 0);
      check("t6/rd_valid", 32'(bus.rd_valid), 0);
      check("t6/rd_data", 32'(bus.rd_data), 0);
      check("t6/done", 32'(bus.done), 0);
      check("t6/err", 32'(bus.err), 0);
      @(posedge clk); #1;
    end
    build_rsp(0, 5'd6, 4);
    run_txn("t6_fresh", 5'd6, 16'h0500, 4'd4, 0, 0, 0, 0);

    for (int k = 0; k < 24; k++) begin
      logic [4:0]  d;
      logic [15:0] a;
      d  = 5'($urandom);
      a  = 16'($urandom);
      rc = 4'($urandom_range(1, MAXW));
      build_rsp(int'($urandom_range(0, 4)), d, int'(rc));
      run_txn("rand", d, a, rc, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
